inst_loader: RTL and testbench

Boot-time writer for the instruction memory that the fetch stage reads. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written through the instruction RAM write port at consecutive word addresses; word 0 corresponds to PC 0x00400000. The core is held in reset via `core_hold_out` until a complete, checksum-verified image has been loaded.

---
 rtl/inst_loader.sv | 98 +++++++++
 tb/tb_inst_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction memory loader: assembles a length-prefixed, XOR-checksummed
// byte stream into big-endian 32-bit words and releases the core once verified.
module inst_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  we_out,
  output logic [ADDR_WIDTH-1:0] waddr_out,
  output logic [31:0]           wdata_out,
  output logic                  core_hold_out,
  output logic                  done_out,
  output logic                  error_out
);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  // Largest legal image fills the RAM exactly; 17 bits so ADDR_WIDTH=16 still works.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  logic [2:0]            state;
  logic [7:0]            len_hi;
  logic [15:0]           n_words;
  logic [15:0]           word_cnt;
  logic [1:0]            byte_cnt;
  logic [23:0]           shift;
  logic [7:0]            csum;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  accept;
  logic [15:0]           len;

  assign in_ready = !reset && (state == S_LEN_HI || state == S_LEN_LO ||
                               state == S_DATA   || state == S_CSUM);
  assign accept        = in_valid && in_ready;
  assign len           = {len_hi, in_data};
  assign core_hold_out = (state != S_DONE);
  assign done_out      = (state == S_DONE);
  assign error_out     = (state == S_ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LEN_HI;
      len_hi    <= 8'd0;
      n_words   <= 16'd0;
      word_cnt  <= 16'd0;
      byte_cnt  <= 2'd0;
      shift     <= 24'd0;
      csum      <= 8'd0;
      addr      <= '0;
      we_out    <= 1'b0;
      waddr_out <= '0;
      wdata_out <= 32'd0;
    end else begin
      we_out <= 1'b0;
      if (accept) begin
        case (state)
          S_LEN_HI: begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            n_words <= len;
            if ({1'b0, len} > MAX_WORDS) state <= S_ERROR;
            else if (len == 16'd0)      state <= S_CSUM;
            else                        state <= S_DATA;
          end
          S_DATA: begin
            csum     <= csum ^ in_data;
            shift    <= {shift[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            // Fourth byte completes the word: issue the RAM write next cycle.
            if (byte_cnt == 2'd3) begin
              we_out    <= 1'b1;
              wdata_out <= {shift, in_data};
              waddr_out <= addr;
              addr      <= addr + 1'b1;
              word_cnt  <= word_cnt + 16'd1;
              if (word_cnt == n_words - 16'd1) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            state <= (in_data == csum) ? S_DONE : S_ERROR;
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomised and directed checks of inst_loader against a stream-level model of
// the image format (length header, big-endian words, XOR checksum).
module tb_inst_loader;

  localparam int AW = 10;
  localparam int MAXW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          we_out;
  logic [AW-1:0] waddr_out;
  logic [31:0]   wdata_out;
  logic          core_hold_out;
  logic          done_out;
  logic          error_out;

  int tests_run = 0;
  int tests_failed = 0;

  inst_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .we_out(we_out), .waddr_out(waddr_out),
    .wdata_out(wdata_out), .core_hold_out(core_hold_out),
    .done_out(done_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'($urandom);
    #1 checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_we", 32'(we_out), 32'd0);
    checkOutput("rst_waddr", 32'(waddr_out), 32'd0);
    checkOutput("rst_wdata", wdata_out, 32'd0);
    checkOutput("rst_hold", 32'(core_hold_out), 32'd1);
    checkOutput("rst_done", 32'(done_out), 32'd0);
    checkOutput("rst_error", 32'(error_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  // Feeds a byte stream (optionally stopping after stop_after accepted bytes) and
  // checks every cycle against what the image format says should happen.
  task automatic applyStimulus(input logic [7:0] s[$], input bit bubble, input int stop_after);
    int n, nw, final_idx, term, idx, cycles, limit, wr;
    logic [7:0] x;
    logic [31:0] word;
    bit acc, exp_we;
    n = (s.size() >= 2) ? (int'(s[0]) * 256 + int'(s[1])) : 0;
    term = 0;
    if (n > MAXW) begin
      nw = 0; final_idx = 1; term = 2;
    end else begin
      nw = n; final_idx = 2 + 4 * n;
      x = 8'd0;
      for (int i = 2; i < 2 + 4 * n; i++) x ^= s[i];
      if (s.size() > final_idx) term = (s[final_idx] == x) ? 1 : 2;
    end
    limit = (stop_after < 0) ? s.size() : stop_after;
    idx = 0; cycles = 0; wr = 0;
    while (idx < limit && cycles < 20 * s.size() + 100) begin
      @(negedge clk);
      in_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = s[idx];
      #1;
      checkOutput("in_ready", 32'(in_ready), 32'd1);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      exp_we = 1'b0;
      if (acc) begin
        exp_we = (idx >= 2) && (idx < 2 + 4 * nw) && ((idx - 2) % 4 == 3);
        idx++;
      end
      checkOutput("we", 32'(we_out), 32'(exp_we));
      if (exp_we) begin
        word = {s[2 + 4 * wr], s[3 + 4 * wr], s[4 + 4 * wr], s[5 + 4 * wr]};
        checkOutput("waddr", 32'(waddr_out), 32'(wr % MAXW));
        checkOutput("wdata", wdata_out, word);
        wr++;
      end
      checkOutput("done", 32'(done_out), 32'(term == 1 && idx > final_idx));
      checkOutput("error", 32'(error_out), 32'(term == 2 && idx > final_idx));
      checkOutput("hold", 32'(core_hold_out), 32'(!(term == 1 && idx > final_idx)));
      cycles++;
    end
    if (idx < limit) checkOutput("timeout", 32'(idx), 32'(limit));
    in_valid = 1'b0;
    if (stop_after < 0 && idx > final_idx) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'($urandom);
      #1 checkOutput("term_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("term_we", 32'(we_out), 32'd0);
      checkOutput("term_done", 32'(done_out), 32'(term == 1));
      checkOutput("term_error", 32'(error_out), 32'(term == 2));
      in_valid = 1'b0;
    end
  endtask

  // Builds a well-formed image of nw random words; corrupt flips the checksum.
  function automatic void buildImage(input int nw, input bit corrupt, output logic [7:0] s[$]);
    logic [7:0] x, b;
    s = {};
    s.push_back(8'(nw >> 8));
    s.push_back(8'(nw));
    x = 8'd0;
    for (int i = 0; i < 4 * nw; i++) begin
      b = 8'($urandom);
      x ^= b;
      s.push_back(b);
    end
    s.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
  endfunction

  initial begin
    logic [7:0] s[$];
    logic [7:0] x;

    doReset();

    s = '{8'h00, 8'h02, 8'h34, 8'h00, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05};
    x = 8'd0;
    for (int i = 2; i < 10; i++) x ^= s[i];
    s.push_back(x);
    applyStimulus(s, 1'b0, -1);
    doReset();

    s[10] = 8'h12;
    applyStimulus(s, 1'b0, -1);
    doReset();

    s[10] = x;
    applyStimulus(s, 1'b1, -1);
    doReset();

    s = '{8'h04, 8'h01};
    applyStimulus(s, 1'b0, -1);
    doReset();

    s = '{8'h00, 8'h00, 8'h00};
    applyStimulus(s, 1'b0, -1);
    doReset();
    s = '{8'h00, 8'h00, 8'h01};
    applyStimulus(s, 1'b0, -1);
    doReset();

    buildImage(2, 1'b0, s);
    applyStimulus(s, 1'b0, 7);
    doReset();
    s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    applyStimulus(s, 1'b0, -1);
    doReset();

    buildImage(MAXW, 1'b0, s);
    applyStimulus(s, 1'b0, -1);
    doReset();

    for (int t = 0; t < 12; t++) begin
      buildImage($urandom_range(0, 6), 1'($urandom_range(0, 2) == 0), s);
      applyStimulus(s, 1'($urandom_range(0, 1)), -1);
      doReset();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
